button_repeat_conditioner: RTL and testbench
============================================

BUTTON_REPEAT_CONDITIONER -- requirements
Module: button_repeat_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 32'd1000000, stable-level cycles to accept a press or release (20 ms at 50 MHz).
REQ-002 Parameter REPEAT_DELAY, default 32'd25000000, held cycles after the first pulse before auto-repeat starts (0.5 s).
REQ-003 Parameter REPEAT_PERIOD, default 32'd10000000, cycles between auto-repeat pulses (0.2 s); all three parameters SHALL be at least 2.
REQ-004 clock  input  1  single system clock; all flops on rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 button_in  input  1  raw, asynchronous, active-high push button.
REQ-007 enable  input  1  tuning enable; gates pulse_out only.
REQ-008 pulse_out  output  1  registered single-cycle increment pulse, feeds the minute/hour increment path.
REQ-009 held_out  output  1  registered level, high while a debounced press is in progress.

Function
REQ-010 button_in SHALL pass through a two-flop synchronizer; all further logic uses the synchronized level (sync).
REQ-011 FSM states SHALL be IDLE, PRESS_DB, HOLD_DELAY, HOLD_REPEAT, RELEASE_DB.
REQ-012 IDLE: sync=1 -> PRESS_DB with 32-bit cycle counter cleared to 0.
REQ-013 PRESS_DB: sync=0 -> IDLE (glitch rejected, no pulse); counter reaches DEBOUNCE_CYCLES-1 with sync=1 -> HOLD_DELAY and issue one pulse.
REQ-014 HOLD_DELAY: sync=0 -> RELEASE_DB; counter reaches REPEAT_DELAY-1 -> HOLD_REPEAT and issue one pulse.
REQ-015 HOLD_REPEAT: sync=0 -> RELEASE_DB; every REPEAT_PERIOD cycles issue one pulse, counter wrapping to 0.
REQ-016 RELEASE_DB: sync=1 clears counter and stays; counter reaches DEBOUNCE_CYCLES-1 with sync=0 -> IDLE.
REQ-017 Counter SHALL clear to 0 on every state transition and never overflow (maximum value parameter-1).
REQ-018 pulse_out SHALL equal (pulse issued) AND enable, registered; high for exactly one cycle per issued pulse.
REQ-019 Latency: first button_in=1 sampled at edge N, steady -> pulse_out high in the cycle after edge N+2+DEBOUNCE_CYCLES.
REQ-020 enable low SHALL suppress pulse_out but NOT alter FSM progression or counters; enable rising mid-hold SHALL not generate an extra pulse.
REQ-021 held_out SHALL be high in HOLD_DELAY, HOLD_REPEAT and RELEASE_DB, low otherwise.
REQ-022 Pulses SHALL never occur on consecutive cycles (guaranteed by parameter minimum 2).

Reset
REQ-023 resetn low SHALL asynchronously force state IDLE, counter 0, synchronizer flops 0, pulse_out 0, held_out 0.
REQ-024 Reset release with button_in already high SHALL be treated as a new press (full debounce, then pulse).
REQ-025 Reset asserted mid-hold SHALL drop pulse_out and held_out the same cycle, with no pulse on release.

Structure
REQ-026 State encoding localparams and default timing constants SHALL live in the shared package/include button_pkg.
REQ-027 The synchronizer SHALL be a sub-module sync_2ff (1-bit, clock, resetn); FSM and counter stay in this module.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-028 Clean press held 8 cycles, enable=1 -> one pulse_out, 6 cycles after first high sample; held_out high until 4 cycles of low after release.
REQ-029 3-cycle high glitch -> no pulse_out, held_out stays 0, FSM back to IDLE.
REQ-030 Press held 30 cycles -> first pulse at +6, second at +16, then every 3 cycles until release.
REQ-031 Release bounce (low 2, high 1, low 5) -> no extra pulse; IDLE only after 4 consecutive low cycles.
REQ-032 enable=0 during hold, raised after 12 cycles -> pulses only at repeat points after the rise; no pulse at the rise itself.
REQ-033 resetn pulsed low mid-repeat -> outputs 0 immediately; button still high -> next pulse 6 cycles after reset release.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and default timing for the button repeat conditioner.
package button_pkg;

    // Conditioner FSM states
    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_PRESS_DB    = 3'd1,
        ST_HOLD_DELAY  = 3'd2,
        ST_HOLD_REPEAT = 3'd3,
        ST_RELEASE_DB  = 3'd4
    } state_e;

    // Default timing at 50 MHz: 20 ms debounce, 0.5 s repeat delay, 0.2 s repeat period
    localparam logic [31:0] DEF_DEBOUNCE_CYCLES = 32'd1000000;
    localparam logic [31:0] DEF_REPEAT_DELAY    = 32'd25000000;
    localparam logic [31:0] DEF_REPEAT_PERIOD   = 32'd10000000;

    // A debounced press is in progress in every state past press debounce
    function automatic logic state_is_held(input state_e s);
        return (s == ST_HOLD_DELAY) || (s == ST_HOLD_REPEAT) || (s == ST_RELEASE_DB);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
module sync_2ff (
    input  logic clock,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Shift the raw level through two stages
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer flops, cleared by reset
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/button_repeat_conditioner.sv
// Debounces a raw push button and produces single-cycle increment pulses,
// with auto-repeat while the button is held.
module button_repeat_conditioner
    import button_pkg::*;
#(
    parameter logic [31:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic [31:0] REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter logic [31:0] REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clock,
    input  logic resetn,
    input  logic button_in,
    input  logic enable,
    output logic pulse_out,
    output logic held_out
);

    localparam logic [31:0] DB_LAST     = DEBOUNCE_CYCLES - 32'd1;
    localparam logic [31:0] DELAY_LAST  = REPEAT_DELAY - 32'd1;
    localparam logic [31:0] PERIOD_LAST = REPEAT_PERIOD - 32'd1;

    logic        sync;
    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        pulse_q, pulse_d;
    logic        held_q, held_d;
    logic        pulse_issue;

    sync_2ff u_sync (
        .clock  (clock),
        .resetn (resetn),
        .d      (button_in),
        .q      (sync)
    );

    // Next state, counter and pulse issue; counter clears on every transition
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 32'd1;
        pulse_issue = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (sync) state_d = ST_PRESS_DB;
            end
            ST_PRESS_DB: begin
                if (!sync) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d     = ST_HOLD_DELAY;
                    cnt_d       = '0;
                    pulse_issue = 1'b1;
                end
            end
            ST_HOLD_DELAY: begin
                if (!sync) begin
                    state_d = ST_RELEASE_DB;
                    cnt_d   = '0;
                end else if (cnt_q == DELAY_LAST) begin
                    state_d     = ST_HOLD_REPEAT;
                    cnt_d       = '0;
                    pulse_issue = 1'b1;
                end
            end
            ST_HOLD_REPEAT: begin
                if (!sync) begin
                    state_d = ST_RELEASE_DB;
                    cnt_d   = '0;
                end else if (cnt_q == PERIOD_LAST) begin
                    cnt_d       = '0;
                    pulse_issue = 1'b1;
                end
            end
            ST_RELEASE_DB: begin
                if (sync) begin
                    cnt_d = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        // enable gates only the output, never the FSM, so raising it mid-hold adds no pulse
        pulse_d = pulse_issue & enable;
        held_d  = state_is_held(state_d);
    end

    // State, counter and registered outputs
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            held_q  <= held_d;
        end
    end

    assign pulse_out = pulse_q;
    assign held_out  = held_q;

endmodule

// File: tb/tb_button_repeat_conditioner.sv
// Self-checking bench for button_repeat_conditioner with small timing parameters.
module tb_button_repeat_conditioner;

    localparam int unsigned D = 4;
    localparam int unsigned R = 10;
    localparam int unsigned P = 3;

    logic clock = 1'b0;
    logic resetn;
    logic button_in;
    logic enable;
    logic pulse_out;
    logic held_out;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    button_repeat_conditioner #(
        .DEBOUNCE_CYCLES (32'(D)),
        .REPEAT_DELAY    (32'(R)),
        .REPEAT_PERIOD   (32'(P))
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .button_in (button_in),
        .enable    (enable),
        .pulse_out (pulse_out),
        .held_out  (held_out)
    );

    always #5 clock = ~clock;

    // Reference model: run lengths of the synchronized level and press age
    logic        m_s1, m_s2;
    int unsigned m_hi, m_lo, m_age;
    bit          m_pressed, m_releasing;
    logic        m_pulse, m_held;

    // Per-scenario observation
    logic prev_pulse;
    int   n_pulses;
    int   first_pulse;
    int   scen_step;

    function automatic void model_reset();
        m_s1 = 1'b0; m_s2 = 1'b0;
        m_hi = 0; m_lo = 0; m_age = 0;
        m_pressed = 1'b0; m_releasing = 1'b0;
        m_pulse = 1'b0; m_held = 1'b0;
    endfunction

    function automatic void model_edge(input logic b, input logic en);
        logic s;
        logic fire;
        s    = m_s2;
        fire = 1'b0;
        if (!m_pressed) begin
            // accepted after one idle sample plus D debounce samples, all high
            m_hi = s ? m_hi + 1 : 0;
            if (m_hi == D + 1) begin
                m_pressed = 1'b1; m_releasing = 1'b0; m_age = 0; m_hi = 0;
                fire = 1'b1;
            end
        end else if (!m_releasing) begin
            if (!s) begin
                m_releasing = 1'b1; m_lo = 0;
            end else begin
                m_age++;
                if (m_age >= R && ((m_age - R) % P) == 0) fire = 1'b1;
            end
        end else begin
            // any high sample restarts the release wait; D further lows end the press
            m_lo = s ? 0 : m_lo + 1;
            if (m_lo == D) begin
                m_pressed = 1'b0; m_hi = 0;
            end
        end
        m_s2    = m_s1;
        m_s1    = b;
        m_pulse = fire & en;
        m_held  = m_pressed;
    endfunction

    task automatic check_outputs(input string tag);
        n_checks++;
        assert (pulse_out === m_pulse) else begin
            n_fail++;
            $error("FAIL %s pulse_out observed %0b expected %0b", tag, pulse_out, m_pulse);
        end
        n_checks++;
        assert (held_out === m_held) else begin
            n_fail++;
            $error("FAIL %s held_out observed %0b expected %0b", tag, held_out, m_held);
        end
        n_checks++;
        assert (!(pulse_out === 1'b1 && prev_pulse === 1'b1)) else begin
            n_fail++;
            $error("FAIL %s back_to_back observed 1 expected 0", tag);
        end
        if (pulse_out === 1'b1) begin
            n_pulses++;
            if (first_pulse < 0) first_pulse = scen_step;
        end
        prev_pulse = pulse_out;
    endtask

    // One clock: drive at the falling edge, sample 1 time unit after the rising edge
    task automatic step(input logic b, input logic en, input string tag);
        button_in = b;
        enable    = en;
        @(posedge clock);
        model_edge(b, en);
        #1;
        check_outputs(tag);
        scen_step++;
        @(negedge clock);
    endtask

    task automatic run(input logic b, input logic en, input int unsigned n, input string tag);
        for (int unsigned i = 0; i < n; i++) step(b, en, tag);
    endtask

    task automatic new_scenario();
        n_pulses    = 0;
        first_pulse = -1;
        scen_step   = 0;
    endtask

    task automatic check_int(input string tag, input int observed, input int expected);
        n_checks++;
        assert (observed == expected) else begin
            n_fail++;
            $error("FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Assert reset between edges, check outputs drop at once, release two cycles later
    task automatic pulse_reset(input string tag);
        resetn = 1'b0;
        #1;
        n_checks++;
        assert (pulse_out === 1'b0 && held_out === 1'b0) else begin
            n_fail++;
            $error("FAIL %s observed pulse=%0b held=%0b expected pulse=0 held=0", tag, pulse_out, held_out);
        end
        model_reset();
        prev_pulse = 1'b0;
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    initial begin
        logic b;
        logic en;
        int unsigned len;

        model_reset();
        prev_pulse = 1'b0;
        new_scenario();
        button_in = 1'b0;
        enable    = 1'b1;
        resetn    = 1'b0;
        @(negedge clock);
        @(negedge clock);

        // Reset state
        n_checks++;
        assert (pulse_out === 1'b0 && held_out === 1'b0) else begin
            n_fail++;
            $error("FAIL reset_state observed pulse=%0b held=%0b expected pulse=0 held=0", pulse_out, held_out);
        end
        resetn = 1'b1;
        run(1'b0, 1'b1, 4, "idle");

        // Clean press held 8 cycles
        new_scenario();
        run(1'b1, 1'b1, 8, "clean_press");
        run(1'b0, 1'b1, 16, "clean_release");
        check_int("clean_pulse_count", n_pulses, 1);
        check_int("clean_first_pulse", first_pulse, 6);

        // 3-cycle glitch
        new_scenario();
        run(1'b1, 1'b1, 3, "glitch_high");
        run(1'b0, 1'b1, 10, "glitch_low");
        check_int("glitch_pulse_count", n_pulses, 0);

        // Long hold with auto-repeat
        new_scenario();
        run(1'b1, 1'b1, 30, "hold30");
        run(1'b0, 1'b1, 12, "hold30_release");
        check_int("hold30_pulse_count", n_pulses, 7);
        check_int("hold30_first_pulse", first_pulse, 6);

        // Release bounce
        new_scenario();
        run(1'b1, 1'b1, 12, "bounce_hold");
        run(1'b0, 1'b1, 2, "bounce_low2");
        run(1'b1, 1'b1, 1, "bounce_high1");
        run(1'b0, 1'b1, 5, "bounce_low5");
        run(1'b0, 1'b1, 8, "bounce_tail");
        check_int("bounce_pulse_count", n_pulses, 1);

        // enable held low for the first 12 cycles of a hold
        new_scenario();
        run(1'b1, 1'b0, 12, "en_low_hold");
        run(1'b1, 1'b1, 18, "en_high_hold");
        run(1'b0, 1'b1, 12, "en_release");
        check_int("enable_pulse_count", n_pulses, 6);
        check_int("enable_first_pulse", first_pulse, 16);

        // Reset mid-repeat with the button still pressed
        new_scenario();
        run(1'b1, 1'b1, 25, "pre_reset_hold");
        button_in = 1'b1;
        pulse_reset("reset_mid_hold");
        new_scenario();
        run(1'b1, 1'b1, 15, "post_reset_hold");
        check_int("post_reset_first_pulse", first_pulse, 6);
        run(1'b0, 1'b1, 12, "post_reset_release");

        // Random runs of button level and enable
        for (int unsigned k = 0; k < 120; k++) begin
            b   = logic'($urandom_range(0, 1));
            en  = logic'($urandom_range(0, 3) != 0);
            len = $urandom_range(1, 22);
            run(b, en, len, "random");
            if (k == 60) begin
                button_in = b;
                pulse_reset("random_reset");
            end
        end
        run(1'b0, 1'b1, 10, "final_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
